tag_free_list: RTL and testbench

//  Circular free list of rename tags for the dispatcher. Supplies a fresh rd_tag
//  to the register status table on every tag write (tag_write_en). Recycles tags

---
 rtl/tag_free_list.sv | 98 +++++++++
 tb/tb_tag_free_list.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_free_list.sv
// Circular free list of rename tags. Tags 1..DEPTH-1 start in the pool; tags freed
// on the CDB are appended and reissued in FIFO order. Tag 0 means "no tag".
module tag_free_list #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pop_req,
  output logic [TAG_W-1:0] tag_out,
  output logic             tag_valid,
  input  logic             push_valid,
  input  logic [TAG_W-1:0] push_tag,
  output logic [CNT_W-1:0] free_count,
  output logic             full,
  output logic             overflow_err
);

  localparam logic [TAG_W-1:0] LAST_PTR = TAG_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [TAG_W-1:0] mem_reg [DEPTH];
  logic [TAG_W-1:0] slot_init [DEPTH];
  logic [DEPTH-1:0] slot_we;

  logic [TAG_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [TAG_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0] free_count_reg, free_count_next;
  logic             overflow_err_reg;

  logic pop_eff;
  logic push_ok;
  logic push_eff;
  logic push_drop;

  assign tag_out      = mem_reg[rd_ptr_reg];
  assign tag_valid    = (free_count_reg != '0);
  assign full         = (free_count_reg == FULL_CNT);
  assign free_count   = free_count_reg;
  assign overflow_err = overflow_err_reg;

  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign pop_eff   = pop_req && tag_valid;
  assign push_ok   = push_valid && (push_tag != '0);
  assign push_eff  = push_ok && (!full || pop_eff);
  assign push_drop = push_ok && full && !pop_eff;

  assign rd_ptr_next     = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
  assign wr_ptr_next     = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
  assign free_count_next = free_count_reg + CNT_W'(push_eff) - CNT_W'(pop_eff);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      // Slot i initially holds tag i+1; the last slot is the empty write position.
      localparam logic [TAG_W-1:0] INIT = (gi < DEPTH - 1) ? TAG_W'(gi + 1) : '0;
      assign slot_init[gi] = INIT;
      assign slot_we[gi]   = push_eff && (wr_ptr_reg == TAG_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= slot_init[i];
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slot_we[i]) begin
          mem_reg[i] <= push_tag;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= LAST_PTR;
      free_count_reg   <= CNT_W'(DEPTH - 1);
      overflow_err_reg <= 1'b0;
    end else begin
      if (pop_eff) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      if (push_eff) begin
        wr_ptr_reg <= wr_ptr_next;
      end
      free_count_reg <= free_count_next;
      // Dropping a push at full means a tag was freed twice; keep the flag until reset.
      if (push_drop) begin
        overflow_err_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tag_free_list.sv
// Bench for tag_free_list: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the free pool.
module tb_tag_free_list;

  localparam int TAG_W = 6;
  localparam int DEPTH = 64;
  localparam int CNT_W = 7;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pop_req = 1'b0;
  logic             push_valid = 1'b0;
  logic [TAG_W-1:0] push_tag = '0;
  logic [TAG_W-1:0] tag_out;
  logic             tag_valid;
  logic [CNT_W-1:0] free_count;
  logic             full;
  logic             overflow_err;

  tag_free_list #(.TAG_W(TAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .pop_req      (pop_req),
    .tag_out      (tag_out),
    .tag_valid    (tag_valid),
    .push_valid   (push_valid),
    .push_tag     (push_tag),
    .free_count   (free_count),
    .full         (full),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: the pool as an ordered queue of tags plus a sticky error bit.
  int q[$];
  bit m_ovf;
  int n_checks = 0;
  int n_pass = 0;

  task automatic model_reset();
    q.delete();
    for (int i = 1; i < DEPTH; i++) q.push_back(i);
    m_ovf = 1'b0;
  endtask

  function automatic int exp_head();
    return (q.size() != 0) ? q[0] : -1;
  endfunction

  // One clock of stimulus; model follows the pool rules; outputs settle at edge+1.
  task automatic drive(input bit p, input bit pv, input int t);
    bit pe, ok, pu;
    pop_req    = p;
    push_valid = pv;
    push_tag   = TAG_W'(t);
    @(posedge clk);
    pe = p && (q.size() != 0);
    ok = pv && (t != 0);
    pu = ok && ((q.size() != DEPTH) || pe);
    if (ok && (q.size() == DEPTH) && !pe) m_ovf = 1'b1;
    if (pe) void'(q.pop_front());
    if (pu) q.push_back(t);
    #1;
    pop_req    = 1'b0;
    push_valid = 1'b0;
    $display("txn pop=%0b push=%0b tag=%0d -> tag_out=%0d valid=%0b count=%0d full=%0b ovf=%0b",
             p, pv, t, tag_out, tag_valid, free_count, full, overflow_err);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #17;
    n_checks++;
    if (tag_out !== 6'd1 || tag_valid !== 1'b1 || free_count !== 7'd63 ||
        full !== 1'b0 || overflow_err !== 1'b0)
      $display("FAIL reset_held: tag=%0d valid=%0b count=%0d full=%0b ovf=%0b, want 1 1 63 0 0",
               tag_out, tag_valid, free_count, full, overflow_err);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (tag_out !== 6'd1 || tag_valid !== 1'b1 || free_count !== 7'd63 ||
        full !== 1'b0 || overflow_err !== 1'b0)
      $display("FAIL reset_released: tag=%0d valid=%0b count=%0d full=%0b ovf=%0b, want 1 1 63 0 0",
               tag_out, tag_valid, free_count, full, overflow_err);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_drain();
    for (int i = 1; i < DEPTH; i++) begin
      n_checks++;
      if (tag_out !== TAG_W'(i) || tag_valid !== 1'b1)
        $display("FAIL drain_seq[%0d]: tag=%0d valid=%0b, want %0d 1", i, tag_out, tag_valid, i);
      else n_pass++;
      drive(1, 0, 0);
    end
    n_checks++;
    if (free_count !== 7'd0 || tag_valid !== 1'b0)
      $display("FAIL drain_empty: count=%0d valid=%0b, want 0 0", free_count, tag_valid);
    else n_pass++;
    drive(1, 0, 0);
    n_checks++;
    if (free_count !== 7'd0 || tag_valid !== 1'b0 || full !== 1'b0)
      $display("FAIL pop_when_empty: count=%0d valid=%0b full=%0b, want 0 0 0",
               free_count, tag_valid, full);
    else n_pass++;
  endtask

  task automatic test_recycle();
    drive(0, 1, 9);
    drive(0, 1, 4);
    drive(0, 1, 0);
    n_checks++;
    if (free_count !== 7'd2 || tag_out !== 6'd9 || tag_valid !== 1'b1)
      $display("FAIL recycle_load: count=%0d tag=%0d valid=%0b, want 2 9 1",
               free_count, tag_out, tag_valid);
    else n_pass++;
    drive(1, 0, 0);
    n_checks++;
    if (free_count !== 7'd1 || tag_out !== 6'd4)
      $display("FAIL recycle_pop1: count=%0d tag=%0d, want 1 4", free_count, tag_out);
    else n_pass++;
    drive(1, 0, 0);
    n_checks++;
    if (free_count !== 7'd0 || tag_valid !== 1'b0)
      $display("FAIL recycle_pop2: count=%0d valid=%0b, want 0 0", free_count, tag_valid);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    #3 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    drive(1, 1, 7);
    n_checks++;
    if (free_count !== 7'd63 || tag_out !== 6'd2)
      $display("FAIL simul_at_63: count=%0d tag=%0d, want 63 2", free_count, tag_out);
    else n_pass++;
    while (q.size() != 0) drive(1, 0, 0);
    n_checks++;
    if (free_count !== 7'd0 || tag_valid !== 1'b0)
      $display("FAIL simul_drain: count=%0d valid=%0b, want 0 0", free_count, tag_valid);
    else n_pass++;
    drive(1, 1, 5);
    n_checks++;
    if (free_count !== 7'd1 || tag_out !== 6'd5 || tag_valid !== 1'b1)
      $display("FAIL simul_at_empty: count=%0d tag=%0d valid=%0b, want 1 5 1",
               free_count, tag_out, tag_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int k = 0;
    while (q.size() != DEPTH) begin
      drive(0, 1, (k % 63) + 1);
      k++;
    end
    n_checks++;
    if (free_count !== 7'd64 || full !== 1'b1 || overflow_err !== 1'b0)
      $display("FAIL fill_full: count=%0d full=%0b ovf=%0b, want 64 1 0",
               free_count, full, overflow_err);
    else n_pass++;
    drive(0, 1, 12);
    n_checks++;
    if (free_count !== 7'd64 || overflow_err !== 1'b1)
      $display("FAIL overflow_drop: count=%0d ovf=%0b, want 64 1", free_count, overflow_err);
    else n_pass++;
    drive(0, 0, 0);
    n_checks++;
    if (overflow_err !== 1'b1)
      $display("FAIL overflow_sticky: ovf=%0b, want 1", overflow_err);
    else n_pass++;
    drive(1, 1, 12);
    n_checks++;
    if (free_count !== 7'd64 || overflow_err !== 1'b1 || tag_out !== TAG_W'(exp_head()))
      $display("FAIL full_push_pop: count=%0d ovf=%0b tag=%0d, want 64 1 %0d",
               free_count, overflow_err, tag_out, exp_head());
    else n_pass++;
  endtask

  task automatic test_random();
    int p_pop;
    int p_push;
    for (int c = 0; c < 600; c++) begin
      // Phases alternate between draining and filling so both bounds are exercised.
      p_pop  = ((c / 100) % 2 == 0) ? 80 : 25;
      p_push = ((c / 100) % 2 == 0) ? 30 : 85;
      drive($urandom_range(99) < p_pop, $urandom_range(99) < p_push, $urandom_range(63));
      n_checks++;
      if (free_count !== CNT_W'(q.size()) || tag_valid !== (q.size() != 0) ||
          full !== (q.size() == DEPTH) || overflow_err !== m_ovf ||
          (q.size() != 0 && tag_out !== TAG_W'(exp_head())))
        $display("FAIL random[%0d]: count=%0d valid=%0b full=%0b ovf=%0b tag=%0d, want %0d %0b %0b %0b %0d",
                 c, free_count, tag_valid, full, overflow_err, tag_out,
                 q.size(), q.size() != 0, q.size() == DEPTH, m_ovf, exp_head());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    while (q.size() != DEPTH) drive(0, 1, $urandom_range(1, 63));
    drive(0, 1, 3);
    for (int i = 0; i < 5; i++) drive(1, 1, $urandom_range(1, 63));
    pop_req    = 1'b1;
    push_valid = 1'b1;
    push_tag   = 6'd33;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (tag_out !== 6'd1 || tag_valid !== 1'b1 || free_count !== 7'd63 ||
        full !== 1'b0 || overflow_err !== 1'b0)
      $display("FAIL async_reset: tag=%0d valid=%0b count=%0d full=%0b ovf=%0b, want 1 1 63 0 0",
               tag_out, tag_valid, free_count, full, overflow_err);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if (tag_out !== 6'd1 || free_count !== 7'd63)
      $display("FAIL reset_holds_over_edge: tag=%0d count=%0d, want 1 63", tag_out, free_count);
    else n_pass++;
    @(negedge clk);
    pop_req    = 1'b0;
    push_valid = 1'b0;
    rst        = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    drive(1, 0, 0);
    n_checks++;
    if (tag_out !== 6'd2 || free_count !== 7'd62)
      $display("FAIL post_reset_pop: tag=%0d count=%0d, want 2 62", tag_out, free_count);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_drain();
    test_recycle();
    test_simultaneous();
    test_overflow();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
